// File: rtl/mem_bus_ctrl.sv
// mem_bus_ctrl: memory-side bus controller for the ARMv4T core.
// Accepts one read or write at a time, decodes the GBA address map into a
// backing-memory region select, inserts per-region wait states and drives a
// single synchronous memory port. Read data is returned lane-aligned to bit 0.
//
// Optional feature macro: MEM_BUS_CTRL_ROTATE_EN
//   defined   - misaligned word reads return the aligned word rotated right
//               by 8*addr[1:0] (ARMv4 LDR behaviour)
//   undefined - misaligned word reads return the aligned word unrotated
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   mem_addr   core request byte address
//   mem_data   write data from core / read data to core (driven in DATA only)
//   mem_width  0 byte, 1 halfword, 2/3 word
//   mem_read   read request (wins when both requests are high)
//   mem_write  write request
//   mem_ok     one-cycle completion pulse
//   ram_en     backing-memory access strobe
//   ram_we     backing-memory write enable
//   ram_sel    0 BIOS, 1 EWRAM, 2 IWRAM, 3 ROM
//   ram_addr   word-aligned byte offset within the region
//   ram_be     byte-lane enables
//   ram_wdata  lane-replicated write data
//   ram_rdata  read word, valid the cycle after ram_en
module mem_bus_ctrl #(
    parameter int unsigned BIOS_WAIT  = 0,
    parameter int unsigned EWRAM_WAIT = 2,
    parameter int unsigned ROM_WAIT   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] mem_addr,
    inout  wire  [31:0] mem_data,
    input  logic [1:0]  mem_width,
    input  logic        mem_read,
    input  logic        mem_write,
    output logic        mem_ok,
    output logic        ram_en,
    output logic        ram_we,
    output logic [1:0]  ram_sel,
    output logic [24:0] ram_addr,
    output logic [3:0]  ram_be,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata
);

    localparam logic [3:0] BIOS_W_C  = 4'(BIOS_WAIT);
    localparam logic [3:0] EWRAM_W_C = 4'(EWRAM_WAIT);
    localparam logic [3:0] ROM_W_C   = 4'(ROM_WAIT);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACCESS = 2'd2,
        ST_DATA   = 2'd3
    } state_t;

    // Aligns the returned memory word to bit 0 according to width and lane.
    function automatic logic [31:0] align_rdata(input logic [31:0] w,
                                                input logic [1:0]  lane,
                                                input logic [1:0]  width);
        logic [31:0] r;
        case (width)
            2'd0: begin
                case (lane)
                    2'd0:    r = {24'h0, w[7:0]};
                    2'd1:    r = {24'h0, w[15:8]};
                    2'd2:    r = {24'h0, w[23:16]};
                    default: r = {24'h0, w[31:24]};
                endcase
            end
            2'd1:    r = lane[1] ? {16'h0, w[31:16]} : {16'h0, w[15:0]};
`ifdef MEM_BUS_CTRL_ROTATE_EN
            default: begin
                case (lane)
                    2'd0:    r = w;
                    2'd1:    r = {w[7:0],  w[31:8]};
                    2'd2:    r = {w[15:0], w[31:16]};
                    default: r = {w[23:0], w[31:24]};
                endcase
            end
`else
            default: r = w;
`endif
        endcase
        return r;
    endfunction

    state_t      state_r, state_next_s;
    logic [3:0]  cnt_r, cnt_next_s;
    logic        mem_ok_r, ram_en_r, ram_we_r;
    logic [1:0]  ram_sel_r;
    logic [24:0] ram_addr_r;
    logic [3:0]  ram_be_r;
    logic [31:0] ram_wdata_r;
    logic        is_read_r, en_ok_r, mapped_r;
    logic [1:0]  lane_r, width_r;

    logic [1:0]  dec_sel_s;
    logic [24:0] dec_off_s;
    logic [3:0]  dec_wait_s;
    logic        dec_mapped_s, dec_wr_ok_s;
    logic [3:0]  req_be_s;
    logic [31:0] req_wdata_s;
    logic        req_en_s;
    logic        accept_s, ram_en_next_s, ram_we_next_s;
    logic        drive_s;
    logic [31:0] rdata_align_s;
    logic        unused_s;

    // Bits 31:28 of the address do not take part in the decode.
    assign unused_s = ^mem_addr[31:28];

    // Region decode of the incoming request address.
    always_comb begin
        dec_sel_s    = 2'd0;
        dec_off_s    = 25'd0;
        dec_wait_s   = 4'd0;
        dec_mapped_s = 1'b0;
        dec_wr_ok_s  = 1'b0;
        case (mem_addr[27:24])
            4'h0: begin
                dec_sel_s    = 2'd0;
                dec_off_s    = {11'd0, mem_addr[13:2], 2'b00};
                dec_wait_s   = BIOS_W_C;
                dec_mapped_s = 1'b1;
            end
            4'h2: begin
                dec_sel_s    = 2'd1;
                dec_off_s    = {7'd0, mem_addr[17:2], 2'b00};
                dec_wait_s   = EWRAM_W_C;
                dec_mapped_s = 1'b1;
                dec_wr_ok_s  = 1'b1;
            end
            4'h3: begin
                dec_sel_s    = 2'd2;
                dec_off_s    = {10'd0, mem_addr[14:2], 2'b00};
                dec_wait_s   = 4'd0;
                dec_mapped_s = 1'b1;
                dec_wr_ok_s  = 1'b1;
            end
            4'h8, 4'h9, 4'hA, 4'hB, 4'hC, 4'hD: begin
                dec_sel_s    = 2'd3;
                dec_off_s    = {mem_addr[24:2], 2'b00};
                dec_wait_s   = ROM_W_C;
                dec_mapped_s = 1'b1;
            end
            default: begin
                dec_sel_s    = 2'd0;
                dec_off_s    = 25'd0;
                dec_wait_s   = 4'd0;
                dec_mapped_s = 1'b0;
                dec_wr_ok_s  = 1'b0;
            end
        endcase
    end

    // Byte-lane enables and lane-replicated write data for the request.
    always_comb begin
        req_be_s    = 4'hF;
        req_wdata_s = mem_data;
        case (mem_width)
            2'd0: begin
                req_be_s    = 4'b0001 << mem_addr[1:0];
                req_wdata_s = {4{mem_data[7:0]}};
            end
            2'd1: begin
                req_be_s    = mem_addr[1] ? 4'b1100 : 4'b0011;
                req_wdata_s = {2{mem_data[15:0]}};
            end
            default: begin
                req_be_s    = 4'hF;
                req_wdata_s = mem_data;
            end
        endcase
    end

    // Reads always touch mapped memory; writes only when the region is writable.
    assign req_en_s = dec_mapped_s & (mem_read | dec_wr_ok_s);

    // Next-state, wait counter and next access strobe.
    always_comb begin
        state_next_s  = state_r;
        cnt_next_s    = cnt_r;
        accept_s      = 1'b0;
        ram_en_next_s = 1'b0;
        ram_we_next_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (mem_read | mem_write) begin
                    accept_s   = 1'b1;
                    cnt_next_s = dec_wait_s;
                    if (dec_wait_s != 4'd0) begin
                        state_next_s = ST_WAIT;
                    end else begin
                        state_next_s  = ST_ACCESS;
                        ram_en_next_s = req_en_s;
                        ram_we_next_s = req_en_s & ~mem_read;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                // Leave on a count of 1 so the access lands W cycles after IDLE.
                if (cnt_r <= 4'd1) begin
                    cnt_next_s    = 4'd0;
                    state_next_s  = ST_ACCESS;
                    ram_en_next_s = en_ok_r;
                    ram_we_next_s = en_ok_r & ~is_read_r;
                end else begin
                    cnt_next_s   = cnt_r - 4'd1;
                    state_next_s = ST_WAIT;
                end
            end
            ST_ACCESS: state_next_s = ST_DATA;
            ST_DATA:   state_next_s = ST_IDLE;
            default:   state_next_s = ST_IDLE;
        endcase
    end

    // State, counter, request latches and registered memory-port outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            cnt_r       <= 4'd0;
            mem_ok_r    <= 1'b0;
            ram_en_r    <= 1'b0;
            ram_we_r    <= 1'b0;
            ram_sel_r   <= 2'd0;
            ram_addr_r  <= 25'd0;
            ram_be_r    <= 4'd0;
            ram_wdata_r <= 32'd0;
            is_read_r   <= 1'b0;
            en_ok_r     <= 1'b0;
            mapped_r    <= 1'b0;
            lane_r      <= 2'd0;
            width_r     <= 2'd0;
        end else begin
            state_r  <= state_next_s;
            cnt_r    <= cnt_next_s;
            mem_ok_r <= (state_next_s == ST_DATA);
            ram_en_r <= ram_en_next_s;
            ram_we_r <= ram_we_next_s;
            if (accept_s) begin
                ram_sel_r   <= dec_sel_s;
                ram_addr_r  <= dec_off_s;
                ram_be_r    <= req_be_s;
                ram_wdata_r <= req_wdata_s;
                is_read_r   <= mem_read;
                en_ok_r     <= req_en_s;
                mapped_r    <= dec_mapped_s;
                lane_r      <= mem_addr[1:0];
                width_r     <= mem_width;
            end
        end
    end

    assign mem_ok    = mem_ok_r;
    assign ram_en    = ram_en_r;
    assign ram_we    = ram_we_r;
    assign ram_sel   = ram_sel_r;
    assign ram_addr  = ram_addr_r;
    assign ram_be    = ram_be_r;
    assign ram_wdata = ram_wdata_r;

    // Unmapped reads return zero; memory data is only valid in DATA.
    assign rdata_align_s = mapped_r ? align_rdata(ram_rdata, lane_r, width_r) : 32'd0;
    assign drive_s       = (state_r == ST_DATA) && is_read_r;
    assign mem_data      = drive_s ? rdata_align_s : 32'hzzzz_zzzz;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Testbench for mem_bus_ctrl: table of directed transactions plus
// hand-written sequences for reset-in-WAIT and back-to-back acceptance.
module tb_mem_bus_ctrl;

    logic        clk;
    logic        rst;
    logic [31:0] mem_addr;
    wire  [31:0] mem_data;
    logic [1:0]  mem_width;
    logic        mem_read;
    logic        mem_write;
    logic        mem_ok;
    logic        ram_en;
    logic        ram_we;
    logic [1:0]  ram_sel;
    logic [24:0] ram_addr;
    logic [3:0]  ram_be;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;

    logic        tb_drv;
    logic [31:0] tb_wd;
    logic [31:0] ram_mem [0:3][0:255];

    int errors = 0;
    int checks = 0;

    assign mem_data = tb_drv ? tb_wd : 32'hzzzz_zzzz;

    mem_bus_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .mem_width (mem_width),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_ok    (mem_ok),
        .ram_en    (ram_en),
        .ram_we    (ram_we),
        .ram_sel   (ram_sel),
        .ram_addr  (ram_addr),
        .ram_be    (ram_be),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Synchronous backing memory with byte enables; BIOS/ROM preloaded on reset.
    always @(posedge clk) begin
        if (rst) begin
            ram_mem[0][2] <= 32'h0BAD_F00D;
            ram_mem[3][1] <= 32'hCAFE_F00D;
        end else if (ram_en) begin
            if (ram_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (ram_be[b]) ram_mem[ram_sel][ram_addr[9:2]][8*b +: 8] <= ram_wdata[8*b +: 8];
                end
            end else begin
                ram_rdata <= ram_mem[ram_sel][ram_addr[9:2]];
            end
        end
    end

    typedef struct packed {
        logic        rd;
        logic        wr;
        logic        hold;
        logic [1:0]  width;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [7:0]  lat;
        logic        en;
        logic [1:0]  sel;
        logic [24:0] raddr;
        logic [3:0]  be;
        logic        we;
        logic [31:0] ramw;
        logic [31:0] rdata;
    } vec_t;

    localparam int NV = 23;
    vec_t vecs [0:NV-1];

`ifdef MEM_BUS_CTRL_ROTATE_EN
    localparam logic [31:0] MISALIGNED_EXP = 32'h4411_2233;
`else
    localparam logic [31:0] MISALIGNED_EXP = 32'h1122_3344;
`endif

    function automatic vec_t mk(input logic rd, input logic wr, input logic hold,
                                input logic [1:0] w, input logic [31:0] a, input logic [31:0] d,
                                input logic [7:0] lat, input logic en, input logic [1:0] sel,
                                input logic [24:0] ra, input logic [3:0] be, input logic we,
                                input logic [31:0] ramw, input logic [31:0] rdata);
        vec_t v;
        v.rd = rd; v.wr = wr; v.hold = hold; v.width = w; v.addr = a; v.wdata = d;
        v.lat = lat; v.en = en; v.sel = sel; v.raddr = ra; v.be = be; v.we = we;
        v.ramw = ramw; v.rdata = rdata;
        return v;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %h expected %h", nm, idx, act, exp);
        end
    endtask

    // Issue one request at a negedge, watch for ram_en and mem_ok, return to IDLE.
    task automatic run_txn(input logic rd, input logic wr, input logic hold, input logic [1:0] w,
                           input logic [31:0] a, input logic [31:0] d,
                           output int lat, output int en_at, output logic [31:0] rdat,
                           output logic [1:0] sel, output logic [24:0] ra, output logic [3:0] be,
                           output logic we, output logic [31:0] wd);
        mem_read = rd; mem_write = wr; mem_width = w; mem_addr = a;
        tb_wd = d; tb_drv = wr & ~rd;
        lat = -1; en_at = -1; rdat = 32'd0; sel = 2'd0; ra = 25'd0; be = 4'd0; we = 1'b0; wd = 32'd0;
        for (int c = 1; c <= 30 && lat < 0; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (!hold) begin
                mem_read = 1'b0; mem_write = 1'b0; tb_drv = 1'b0;
            end
            if (ram_en && en_at < 0) begin
                en_at = c; sel = ram_sel; ra = ram_addr; be = ram_be; we = ram_we; wd = ram_wdata;
            end
            if (mem_ok) begin
                lat = c; rdat = mem_data;
            end
        end
        mem_read = 1'b0; mem_write = 1'b0; tb_drv = 1'b0;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int          lat, en_at;
        logic [31:0] rdat, wd;
        logic [1:0]  sel;
        logic [24:0] ra;
        logic [3:0]  be;
        logic        we;
        logic        seen_ok, seen_en;

        rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0; mem_width = 2'd0; mem_addr = 32'd0;
        tb_drv = 1'b1; tb_wd = 32'hA5A5_5A5A;

        //          rd    wr    hold  w     addr           wdata          lat   en    sel   raddr     be       we    ramw           rdata
        vecs[0]  = mk(1'b0, 1'b1, 1'b1, 2'd2, 32'h0300_0010, 32'hDEAD_BEEF, 8'd2, 1'b1, 2'd2, 25'h10, 4'hF,    1'b1, 32'hDEAD_BEEF, 32'h0);
        vecs[1]  = mk(1'b1, 1'b0, 1'b1, 2'd2, 32'h0300_0010, 32'h0,         8'd2, 1'b1, 2'd2, 25'h10, 4'hF,    1'b0, 32'h0,         32'hDEAD_BEEF);
        vecs[2]  = mk(1'b0, 1'b1, 1'b1, 2'd0, 32'h0200_0003, 32'h1234_565A, 8'd4, 1'b1, 2'd1, 25'h0,  4'b1000, 1'b1, 32'h5A5A_5A5A, 32'h0);
        vecs[3]  = mk(1'b1, 1'b0, 1'b1, 2'd0, 32'h0200_0003, 32'h0,         8'd4, 1'b1, 2'd1, 25'h0,  4'b1000, 1'b0, 32'h0,         32'h0000_005A);
        vecs[4]  = mk(1'b1, 1'b0, 1'b1, 2'd2, 32'h0800_0004, 32'h0,         8'd6, 1'b1, 2'd3, 25'h4,  4'hF,    1'b0, 32'h0,         32'hCAFE_F00D);
        vecs[5]  = mk(1'b0, 1'b1, 1'b1, 2'd2, 32'h0800_0000, 32'h5555_5555, 8'd6, 1'b0, 2'd0, 25'h0,  4'h0,    1'b0, 32'h0,         32'h0);
        vecs[6]  = mk(1'b0, 1'b1, 1'b1, 2'd2, 32'h0300_0020, 32'h1122_3344, 8'd2, 1'b1, 2'd2, 25'h20, 4'hF,    1'b1, 32'h1122_3344, 32'h0);
        vecs[7]  = mk(1'b1, 1'b0, 1'b1, 2'd2, 32'h0300_0021, 32'h0,         8'd2, 1'b1, 2'd2, 25'h20, 4'hF,    1'b0, 32'h0,         MISALIGNED_EXP);
        vecs[8]  = mk(1'b1, 1'b0, 1'b1, 2'd2, 32'h0500_0000, 32'h0,         8'd2, 1'b0, 2'd0, 25'h0,  4'h0,    1'b0, 32'h0,         32'h0);
        vecs[9]  = mk(1'b0, 1'b1, 1'b1, 2'd2, 32'h0300_0030, 32'hAABB_CCDD, 8'd2, 1'b1, 2'd2, 25'h30, 4'hF,    1'b1, 32'hAABB_CCDD, 32'h0);
        vecs[10] = mk(1'b1, 1'b0, 1'b1, 2'd1, 32'h0300_0032, 32'h0,         8'd2, 1'b1, 2'd2, 25'h30, 4'b1100, 1'b0, 32'h0,         32'h0000_AABB);
        vecs[11] = mk(1'b1, 1'b0, 1'b1, 2'd1, 32'h0300_0031, 32'h0,         8'd2, 1'b1, 2'd2, 25'h30, 4'b0011, 1'b0, 32'h0,         32'h0000_CCDD);
        vecs[12] = mk(1'b0, 1'b1, 1'b1, 2'd1, 32'h0300_0042, 32'h0000_BEEF, 8'd2, 1'b1, 2'd2, 25'h40, 4'b1100, 1'b1, 32'hBEEF_BEEF, 32'h0);
        vecs[13] = mk(1'b1, 1'b0, 1'b1, 2'd0, 32'h0300_0043, 32'h0,         8'd2, 1'b1, 2'd2, 25'h40, 4'b1000, 1'b0, 32'h0,         32'h0000_00BE);
        vecs[14] = mk(1'b1, 1'b0, 1'b1, 2'd2, 32'h0000_0008, 32'h0,         8'd2, 1'b1, 2'd0, 25'h8,  4'hF,    1'b0, 32'h0,         32'h0BAD_F00D);
        vecs[15] = mk(1'b1, 1'b0, 1'b1, 2'd2, 32'hF000_0008, 32'h0,         8'd2, 1'b1, 2'd0, 25'h8,  4'hF,    1'b0, 32'h0,         32'h0BAD_F00D);
        vecs[16] = mk(1'b0, 1'b1, 1'b1, 2'd2, 32'h0200_0010, 32'h1357_9BDF, 8'd4, 1'b1, 2'd1, 25'h10, 4'hF,    1'b1, 32'h1357_9BDF, 32'h0);
        vecs[17] = mk(1'b1, 1'b0, 1'b0, 2'd2, 32'h0204_0010, 32'h0,         8'd4, 1'b1, 2'd1, 25'h10, 4'hF,    1'b0, 32'h0,         32'h1357_9BDF);
        vecs[18] = mk(1'b1, 1'b1, 1'b1, 2'd2, 32'h0300_0010, 32'h0,         8'd2, 1'b1, 2'd2, 25'h10, 4'hF,    1'b0, 32'h0,         32'hDEAD_BEEF);
        vecs[19] = mk(1'b0, 1'b1, 1'b1, 2'd2, 32'h0E00_0000, 32'h7777_7777, 8'd2, 1'b0, 2'd0, 25'h0,  4'h0,    1'b0, 32'h0,         32'h0);
        vecs[20] = mk(1'b1, 1'b0, 1'b1, 2'd2, 32'h0300_0010, 32'h0,         8'd2, 1'b1, 2'd2, 25'h10, 4'hF,    1'b0, 32'h0,         32'hDEAD_BEEF);
        vecs[21] = mk(1'b1, 1'b0, 1'b1, 2'd0, 32'h0300_0031, 32'h0,         8'd2, 1'b1, 2'd2, 25'h30, 4'b0010, 1'b0, 32'h0,         32'h0000_00CC);
        vecs[22] = mk(1'b1, 1'b0, 1'b1, 2'd3, 32'h0300_0030, 32'h0,         8'd2, 1'b1, 2'd2, 25'h30, 4'hF,    1'b0, 32'h0,         32'hAABB_CCDD);

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset state; the bench's own drive must be visible on the idle bus.
        chk("rst_mem_ok", 0, {31'd0, mem_ok}, 32'd0);
        chk("rst_ram_en", 0, {31'd0, ram_en}, 32'd0);
        chk("rst_ram_we", 0, {31'd0, ram_we}, 32'd0);
        chk("rst_ram_be", 0, {28'd0, ram_be}, 32'd0);
        chk("rst_ram_sel", 0, {30'd0, ram_sel}, 32'd0);
        chk("rst_ram_addr", 0, {7'd0, ram_addr}, 32'd0);
        chk("rst_ram_wdata", 0, ram_wdata, 32'd0);
        chk("rst_mem_data_z", 0, mem_data, 32'hA5A5_5A5A);
        tb_drv = 1'b0;
        @(posedge clk);
        @(negedge clk);

        for (int i = 0; i < NV; i++) begin
            run_txn(vecs[i].rd, vecs[i].wr, vecs[i].hold, vecs[i].width, vecs[i].addr, vecs[i].wdata,
                    lat, en_at, rdat, sel, ra, be, we, wd);
            chk("latency", i, 32'(lat), {24'd0, vecs[i].lat});
            chk("ram_en_seen", i, {31'd0, en_at >= 0}, {31'd0, vecs[i].en});
            if (vecs[i].en) begin
                chk("ram_en_cycle", i, 32'(en_at), {24'd0, vecs[i].lat} - 32'd1);
                chk("ram_sel", i, {30'd0, sel}, {30'd0, vecs[i].sel});
                chk("ram_addr", i, {7'd0, ra}, {7'd0, vecs[i].raddr});
                chk("ram_be", i, {28'd0, be}, {28'd0, vecs[i].be});
                chk("ram_we", i, {31'd0, we}, {31'd0, vecs[i].we});
                if (vecs[i].we) chk("ram_wdata", i, wd, vecs[i].ramw);
            end
            if (vecs[i].rd) chk("rdata", i, rdat, vecs[i].rdata);
        end

        // Reset during the WAIT of a ROM read drops the access entirely.
        mem_read = 1'b1; mem_write = 1'b0; mem_width = 2'd2; mem_addr = 32'h0800_0004;
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1; mem_read = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("wait_rst_mem_ok", 0, {31'd0, mem_ok}, 32'd0);
        chk("wait_rst_ram_en", 0, {31'd0, ram_en}, 32'd0);
        seen_ok = 1'b0; seen_en = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (mem_ok) seen_ok = 1'b1;
            if (ram_en) seen_en = 1'b1;
        end
        chk("wait_rst_no_ok", 0, {31'd0, seen_ok}, 32'd0);
        chk("wait_rst_no_en", 0, {31'd0, seen_en}, 32'd0);
        run_txn(1'b1, 1'b0, 1'b1, 2'd2, 32'h0300_0010, 32'h0, lat, en_at, rdat, sel, ra, be, we, wd);
        chk("post_rst_latency", 0, 32'(lat), 32'd2);
        chk("post_rst_rdata", 0, rdat, 32'hDEAD_BEEF);

        // Request held continuously: zero-wait accesses complete every 3 cycles.
        mem_read = 1'b1; mem_width = 2'd2; mem_addr = 32'h0300_0010;
        for (int c = 1; c <= 9; c++) begin
            @(posedge clk);
            @(negedge clk);
            chk("b2b_mem_ok", c, {31'd0, mem_ok}, {31'd0, (c % 3) == 2});
            if (mem_ok) chk("b2b_rdata", c, mem_data, 32'hDEAD_BEEF);
        end
        mem_read = 1'b0;
        @(posedge clk);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
